// File: rtl/l3_tx_serializer_if.sv
// Bus bundle between the layer-3 pooled-result buffer, the serializer and the byte UART.
// The master modport is the serializer's view.
interface l3_tx_serializer_if #(
  parameter int DW = 18
);
  logic                   rd;
  logic [3:0][DW-1:0]     din;
  logic                   addr_rd_inc;
  logic                   tx_done;
  logic                   tx_rdy;
  logic                   trmt;
  logic [7:0]             tx_data;

  modport master (
    input  rd,
    input  din,
    input  tx_rdy,
    output addr_rd_inc,
    output tx_done,
    output trmt,
    output tx_data
  );

  modport slave (
    output rd,
    output din,
    output tx_rdy,
    input  addr_rd_inc,
    input  tx_done,
    input  trmt,
    input  tx_data
  );
endinterface

// File: rtl/l3_tx_serializer.sv
// Pops 4x18-bit pooled words from the layer-3 buffer and streams each one as 12 bytes
// (four sign-extended 24-bit lanes, lane 0 first, MSB byte first) to a byte UART.
//
// state | meaning
// IDLE  | wait for the buffer to report a word available
// WAIT  | cover the buffer read latency
// LOAD  | capture din into the shift register, advance the read pointer
// SEND  | offer the next byte once the UART is ready
// GAP   | guard cycle so the UART can drop tx_rdy; choose next byte, word or image end
// DONE  | pulse tx_done and rewind the word counter
module l3_tx_serializer #(
  parameter int NUM_WORDS = 16,
  parameter int DW        = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  l3_tx_serializer_if.master   bus
);

  localparam int LW = 24;
  localparam int NUM_BYTES = 12;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [4:0] LAST_WORD = 5'(NUM_WORDS - 1);
  localparam logic [3:0] BYTES_PER_WORD = 4'(NUM_BYTES);

  logic [2:0]  state;
  logic [3:0]  byte_cnt;
  logic [4:0]  word_cnt;
  logic [95:0] shift;
  logic [95:0] load_word;
  logic [7:0]  tx_data_q;
  logic        send_byte;

  always_comb begin
    load_word = '0;
    for (int i = 0; i < 4; i++) begin
      load_word[95 - LW*i -: LW] = {{(LW-DW){bus.din[i][DW-1]}}, bus.din[i]};
    end
  end

  assign send_byte = (state == S_SEND) && bus.tx_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      shift     <= '0;
      tx_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.rd) state <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          shift    <= load_word;
          byte_cnt <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (send_byte) begin
            tx_data_q <= shift[95:88];
            shift     <= {shift[87:0], 8'h00};
            byte_cnt  <= byte_cnt + 4'd1;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (byte_cnt < BYTES_PER_WORD) begin
            state <= S_SEND;
          end else if (word_cnt == LAST_WORD) begin
            state <= S_DONE;
          end else begin
            word_cnt <= word_cnt + 5'd1;
            state    <= S_IDLE;
          end
        end
        S_DONE: begin
          word_cnt <= '0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The byte is presented combinationally on the trmt cycle and held afterwards.
  assign bus.trmt        = send_byte;
  assign bus.tx_data     = send_byte ? shift[95:88] : tx_data_q;
  assign bus.addr_rd_inc = (state == S_LOAD);
  assign bus.tx_done     = (state == S_DONE);

endmodule

// File: tb/tb_l3_tx_serializer.sv
// Directed bench for l3_tx_serializer: reset abort, single word, back-pressure,
// latency, starvation and two full images through a model read buffer.
module tb_l3_tx_serializer;
  localparam int DW = 18;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l3_tx_serializer_if #(.DW(DW)) bus ();
  l3_tx_serializer_if #(.DW(DW)) bus1 ();

  l3_tx_serializer #(.NUM_WORDS(NW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  l3_tx_serializer #(.NUM_WORDS(1), .DW(DW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // model buffer behind the NW-word instance
  logic [3:0][DW-1:0] mem [32];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic [7:0] q_bytes[$];
  int q_cyc[$];
  int inc_cyc[$];
  int done_cyc[$];
  int bad_rdy = 0;
  int overlap = 0;

  logic [7:0] q1_bytes[$];
  int q1_cyc[$];
  int inc1 = 0;
  int done1_cyc[$];
  int bad_rdy1 = 0;
  int overlap1 = 0;

  logic [7:0] exp_sw [12];

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      rd_ptr = 0;
      wr_ptr = 0;
    end
    bus.rd  = (rd_ptr < wr_ptr);
    bus.din = mem[rd_ptr[4:0]];
    #1;
    if (rst_n) begin
      if (bus.trmt) begin
        q_bytes.push_back(bus.tx_data);
        q_cyc.push_back(cyc);
        if (!bus.tx_rdy) bad_rdy++;
      end
      if (bus.addr_rd_inc) begin
        inc_cyc.push_back(cyc);
        rd_ptr++;
      end
      if (bus.tx_done) begin
        done_cyc.push_back(cyc);
        rd_ptr = 0;
        wr_ptr = 0;
      end
      if (bus.trmt && (bus.tx_done || bus.addr_rd_inc)) overlap++;
      if (bus1.trmt) begin
        q1_bytes.push_back(bus1.tx_data);
        q1_cyc.push_back(cyc);
        if (!bus1.tx_rdy) bad_rdy1++;
      end
      if (bus1.addr_rd_inc) inc1++;
      if (bus1.tx_done) done1_cyc.push_back(cyc);
      if (bus1.trmt && (bus1.tx_done || bus1.addr_rd_inc)) overlap1++;
    end
  end

  function automatic logic [3:0][DW-1:0] gen_word(input int w);
    logic [3:0][DW-1:0] r;
    int v;
    for (int i = 0; i < 4; i++) begin
      v = (i % 2 == 1) ? -(w * 977 + i * 131 + 1) : (w * 8191 + i * 257 + 3);
      r[i] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input int w, input int b);
    logic [3:0][DW-1:0] x;
    logic signed [DW-1:0] lane;
    int v;
    x = gen_word(w);
    lane = x[b / 3];
    v = int'(lane);
    v = v >>> (16 - 8 * (b % 3));
    return v[7:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bytes(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (q_bytes.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_main();
    q_bytes.delete();
    q_cyc.delete();
    inc_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic clear_one();
    q1_bytes.delete();
    q1_cyc.delete();
    done1_cyc.delete();
    inc1 = 0;
  endtask

  task automatic test_reset();
    bit ok;
    int n0;
    int i0;
    rst_n = 1'b0;
    tick(3);
    #3;
    checks++;
    if ({bus.trmt, bus.tx_done, bus.addr_rd_inc, bus.tx_data} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.trmt, bus.tx_done, bus.addr_rd_inc, bus.tx_data});
    end
    checks++;
    if ({bus1.trmt, bus1.tx_done, bus1.addr_rd_inc, bus1.tx_data} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs_nw1 got=%h exp=0", {bus1.trmt, bus1.tx_done, bus1.addr_rd_inc, bus1.tx_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.tx_rdy = 1'b1;
    mem[0] = gen_word(7);
    wr_ptr = 1;
    wait_bytes(3, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_pre_bytes got=%0d exp=3", q_bytes.size());
    end
    @(negedge clk);
    checks++;
    if (bus.trmt !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_send trmt got=%b exp=1", bus.trmt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.trmt, bus.tx_done, bus.addr_rd_inc, bus.tx_data} !== 11'h0) begin
      errors++;
      $display("FAIL reset_abort_outputs got=%h exp=0", {bus.trmt, bus.tx_done, bus.addr_rd_inc, bus.tx_data});
    end
    tick(2);
    rst_n = 1'b1;
    n0 = q_bytes.size();
    i0 = inc_cyc.size();
    tick(50);
    checks++;
    if (q_bytes.size() != n0 || inc_cyc.size() != i0 || done_cyc.size() != 0) begin
      errors++;
      $display("FAIL reset_quiet bytes got=%0d exp=%0d incs got=%0d exp=%0d dones got=%0d exp=0",
               q_bytes.size(), n0, inc_cyc.size(), i0, done_cyc.size());
    end
    clear_main();
  endtask

  task automatic check_single_stream(input string nm);
    checks++;
    if (q1_bytes.size() != 12) begin
      errors++;
      $display("FAIL %s_count got=%0d exp=12", nm, q1_bytes.size());
    end
    for (int k = 0; k < 12 && k < q1_bytes.size(); k++) begin
      checks++;
      if (q1_bytes[k] !== exp_sw[k]) begin
        errors++;
        $display("FAIL %s_byte%0d got=%h exp=%h", nm, k, q1_bytes[k], exp_sw[k]);
      end
    end
    checks++;
    if (inc1 != 1 || done1_cyc.size() != 1) begin
      errors++;
      $display("FAIL %s_pulses inc got=%0d exp=1 done got=%0d exp=1", nm, inc1, done1_cyc.size());
    end
    if (done1_cyc.size() == 1 && q1_cyc.size() == 12) begin
      checks++;
      if (done1_cyc[0] != q1_cyc[11] + 2) begin
        errors++;
        $display("FAIL %s_done_timing got=%0d exp=%0d", nm, done1_cyc[0], q1_cyc[11] + 2);
      end
    end
  endtask

  task automatic test_single_word();
    clear_one();
    bus1.din = {18'h00001, 18'h3FFFF, 18'h1FFFF, 18'h20000};
    bus1.tx_rdy = 1'b1;
    bus1.rd = 1'b1;
    tick(1);
    bus1.rd = 1'b0;
    for (int c = 0; c < 80 && done1_cyc.size() == 0; c++) @(negedge clk);
    tick(5);
    check_single_stream("single");
    checks++;
    if (bus1.tx_data !== 8'h01 || bus1.trmt !== 1'b0) begin
      errors++;
      $display("FAIL single_hold tx_data got=%h exp=01 trmt got=%b exp=0", bus1.tx_data, bus1.trmt);
    end
    checks++;
    if (overlap1 != 0) begin
      errors++;
      $display("FAIL single_overlap got=%0d exp=0", overlap1);
    end
  endtask

  task automatic test_back_pressure();
    int hold;
    clear_one();
    bus1.tx_rdy = 1'b0;
    bus1.rd = 1'b1;
    hold = 40;
    for (int c = 0; c < 3000 && done1_cyc.size() == 0; c++) begin
      @(negedge clk);
      if (c == 0) bus1.rd = 1'b0;
      if (hold == 0) begin
        bus1.tx_rdy = ~bus1.tx_rdy;
        hold = bus1.tx_rdy ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 40));
      end else begin
        hold--;
      end
    end
    bus1.tx_rdy = 1'b1;
    tick(5);
    check_single_stream("backpressure");
    checks++;
    if (bad_rdy1 != 0) begin
      errors++;
      $display("FAIL backpressure_trmt_without_rdy got=%0d exp=0", bad_rdy1);
    end
  endtask

  task automatic test_latency();
    bit ok;
    int c0;
    bit gap_ok;
    clear_main();
    bus.tx_rdy = 1'b1;
    @(negedge clk);
    mem[0] = gen_word(0);
    wr_ptr = 1;
    #3;
    c0 = cyc;
    wait_bytes(12, 100, ok);
    checks++;
    if (!ok || inc_cyc.size() != 1) begin
      errors++;
      $display("FAIL latency_word bytes got=%0d exp=12 incs got=%0d exp=1", q_bytes.size(), inc_cyc.size());
    end else begin
      checks++;
      if (inc_cyc[0] != c0 + 2) begin
        errors++;
        $display("FAIL latency_inc got=%0d exp=%0d", inc_cyc[0] - c0, 2);
      end
      checks++;
      if (q_cyc[0] != c0 + 3) begin
        errors++;
        $display("FAIL latency_first_trmt got=%0d exp=%0d", q_cyc[0] - c0, 3);
      end
      gap_ok = 1'b1;
      for (int k = 1; k < 12; k++) if (q_cyc[k] != q_cyc[k-1] + 2) gap_ok = 1'b0;
      checks++;
      if (!gap_ok) begin
        errors++;
        $display("FAIL latency_trmt_spacing got=%0d exp=%0d", q_cyc[11] - q_cyc[0], 22);
      end
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (q_bytes[k] !== exp_byte(0, k)) begin
          errors++;
          $display("FAIL latency_byte%0d got=%h exp=%h", k, q_bytes[k], exp_byte(0, k));
        end
      end
    end
    tick(4);
  endtask

  task automatic test_starvation();
    bit ok;
    tick(100);
    checks++;
    if (q_bytes.size() != 12 || inc_cyc.size() != 1) begin
      errors++;
      $display("FAIL starve_idle bytes got=%0d exp=12 incs got=%0d exp=1", q_bytes.size(), inc_cyc.size());
    end
    mem[1] = gen_word(1);
    wr_ptr = 2;
    wait_bytes(24, 100, ok);
    checks++;
    if (!ok || inc_cyc.size() != 2) begin
      errors++;
      $display("FAIL starve_resume bytes got=%0d exp=24 incs got=%0d exp=2", q_bytes.size(), inc_cyc.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (q_bytes[12 + k] !== exp_byte(1, k)) begin
          errors++;
          $display("FAIL starve_byte%0d got=%h exp=%h", k, q_bytes[12 + k], exp_byte(1, k));
        end
      end
    end
    tick(4);
  endtask

  task automatic run_bursts(input int first, input int burst);
    bit ok;
    int w;
    int nxt;
    w = first;
    while (w < NW) begin
      nxt = (w + burst > NW) ? NW : w + burst;
      for (int j = w; j < nxt; j++) mem[j] = gen_word(j);
      wr_ptr = nxt;
      wait_bytes(12 * nxt, 12 * burst * 4 + 20, ok);
      if (!ok) break;
      tick(10);
      w = nxt;
    end
  endtask

  task automatic check_image(input string nm);
    checks++;
    if (q_bytes.size() != 12 * NW || inc_cyc.size() != NW || done_cyc.size() != 1) begin
      errors++;
      $display("FAIL %s_counts bytes got=%0d exp=%0d incs got=%0d exp=%0d dones got=%0d exp=1",
               nm, q_bytes.size(), 12 * NW, inc_cyc.size(), NW, done_cyc.size());
    end
    for (int k = 0; k < 12 * NW && k < q_bytes.size(); k++) begin
      checks++;
      if (q_bytes[k] !== exp_byte(k / 12, k % 12)) begin
        errors++;
        $display("FAIL %s_byte%0d got=%h exp=%h", nm, k, q_bytes[k], exp_byte(k / 12, k % 12));
      end
    end
    if (done_cyc.size() == 1 && q_cyc.size() == 12 * NW) begin
      checks++;
      if (done_cyc[0] != q_cyc[12 * NW - 1] + 2) begin
        errors++;
        $display("FAIL %s_done_timing got=%0d exp=%0d", nm, done_cyc[0], q_cyc[12 * NW - 1] + 2);
      end
    end
    checks++;
    if (bad_rdy != 0 || overlap != 0) begin
      errors++;
      $display("FAIL %s_handshake trmt_without_rdy got=%0d overlaps got=%0d exp=0", nm, bad_rdy, overlap);
    end
  endtask

  task automatic test_full_image();
    run_bursts(2, 4);
    check_image("image1");
  endtask

  task automatic test_second_image();
    clear_main();
    run_bursts(0, 8);
    check_image("image2");
  endtask

  initial begin
    exp_sw = '{8'hFE, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 32; i++) mem[i] = '0;
    bus.tx_rdy = 1'b0;
    bus1.rd = 1'b0;
    bus1.din = '0;
    bus1.tx_rdy = 1'b0;
    test_reset();
    test_single_word();
    test_back_pressure();
    test_latency();
    test_starvation();
    test_full_image();
    test_second_image();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l3_tx_serializer.md
Name: l3_tx_serializer

Overview:
- Read-side consumer of the layer-3 pooled-result buffer.
- Pops one 4x18-bit pooled word whenever the buffer reports data available (rd), and serializes it into 12 bytes for a byte-wide UART transmitter using a trmt/tx_rdy handshake.
- After NUM_WORDS words it pulses tx_done, which clears the buffer's read/write pointers for the next image.

Parameters:
- NUM_WORDS, 16, pooled words per image; tx_done fires after the last one. Legal range 1..32.
- DW, 18, width of each pooled value. Fixed at 18 for this release.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rd  input  1  buffer non-empty (read pointer < write pointer); buffer dout is valid 1 cycle after rd is high with a stable read address.
- din  input  4x18  buffer output, lanes din[3:0], signed two's complement.
- addr_rd_inc  output  1  one-cycle pulse; advances the buffer read pointer.
- tx_done  output  1  one-cycle pulse after the last byte of word NUM_WORDS-1 is accepted.
- tx_rdy  input  1  UART idle and able to accept a byte.
- trmt  output  1  one-cycle pulse; UART latches tx_data on this cycle.
- tx_data  output  8  byte to transmit; valid while trmt=1.

Behaviour:
- Reset (async): state=IDLE, byte_cnt=0, word_cnt=0, shift register=0. Outputs addr_rd_inc=0, tx_done=0, trmt=0, tx_data=0.
- Reset asserted mid-operation aborts immediately. The partial word is discarded and no tx_done is issued.
- FSM states: IDLE, WAIT, LOAD, SEND, GAP, DONE.
- IDLE:
  - rd=1 -> WAIT.
  - rd=0 -> remain in IDLE.
- WAIT: one cycle to cover the buffer read latency; always -> LOAD.
- LOAD:
  - Capture din into a 96-bit shift register. Each lane is sign-extended 18->24 bits. Order: lane 0 first, each lane MSB byte first.
  - Pulse addr_rd_inc=1 for exactly this cycle. Clear byte_cnt. Go to SEND.
- SEND:
  - While tx_rdy=0, hold with trmt=0.
  - When tx_rdy=1: trmt=1, tx_data = shift[95:88], shift left by 8, byte_cnt++, -> GAP.
- GAP: one-cycle guard; tx_rdy is ignored so the UART can deassert it.
  - If byte_cnt < 12 -> SEND.
  - Else if word_cnt == NUM_WORDS-1 -> DONE.
  - Else word_cnt++ and -> IDLE.
- DONE: tx_done=1 for one cycle, word_cnt=0 -> IDLE.
- Byte sequence per word: L0[23:16], L0[15:8], L0[7:0], L1[23:16], ... L3[7:0].
  - Example: L0 = 18'h3FFFF (-1) yields bytes FF FF FF.
- Throughput: at most one trmt per 2 cycles.
  - Minimum word time with tx_rdy stuck at 1 is 1 (IDLE) + 1 (WAIT) + 1 (LOAD) + 24 (12 SEND/GAP pairs) = 27 cycles.
- addr_rd_inc pulses exactly once per word, never twice without an intervening LOAD.
- rd dropping after leaving IDLE is ignored; the word in flight completes.
- rd=1 on the DONE cycle is ignored. The FSM re-checks rd in IDLE. The buffer pointers clear on tx_done, so rd is normally 0 afterwards.
- trmt and tx_done are never high in the same cycle; addr_rd_inc and trmt are never high in the same cycle.
- tx_data holds its last value when trmt=0.
- byte_cnt is 4 bits and word_cnt is 5 bits; neither may wrap under legal NUM_WORDS.

Test Plan:
- Reset: assert rst_n=0 mid-SEND -> all outputs 0 next edge, FSM in IDLE; after release with rd=0, no trmt for 50 cycles.
- Single word: NUM_WORDS=1, din={18'h00001, 18'h3FFFF, 18'h1FFFF, 18'h20000} (lanes 3..0), tx_rdy=1.
  - Bytes must be FE 00 00, 01 FF FF, FF FF FF, 00 00 01.
  - Exactly one addr_rd_inc; tx_done pulses once after the 12th trmt.
- Back-pressure: tx_rdy toggled randomly, held low up to 40 cycles -> same byte stream, trmt only when tx_rdy=1, no dropped or duplicated bytes.
- Full image: NUM_WORDS=16 with a model buffer filled in bursts, rd low between bursts.
  - Expect 192 bytes in order, 16 addr_rd_inc pulses, and one tx_done.
  - word_cnt returns to 0 and a second image is then transmitted identically.
- Starvation: rd=0 for 100 cycles between words -> FSM idles with no trmt or addr_rd_inc; resumes the correct next word when rd returns.
- Latency: with tx_rdy=1, rd rising at cycle 0 -> addr_rd_inc at cycle 2 (LOAD), first trmt at cycle 3, subsequent trmt every 2 cycles.
